// File: rtl/pci_arbiter_n.sv
// ---------------------------------------------------------------------------
// pci_arbiter_n
//
// Central PCI bus arbiter for NUM_MASTERS masters. It issues a registered,
// active-low grant to one requester at a time and supports hidden
// arbitration: a grant may be moved to another master while the current
// transaction is still finishing on the bus. A granted master that does not
// start FRAME# within TIMEOUT idle-bus cycles loses the grant.
//
// Each grant change passes through a one-cycle SWITCH state with all grants
// released. This guarantees that two masters never see overlapping grants.
//
// Parameters
//   NUM_MASTERS  number of bus masters (2..16), master NUM_MASTERS-1 has the
//                highest fixed priority
//   TIMEOUT      idle-bus cycles a granted master has to start FRAME# (2..255)
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   asynchronous active-high reset
//   req_n      in   per-master request, active-low (bit i = master i)
//   frame_n    in   PCI FRAME#, active-low
//   irdy_n     in   PCI IRDY#, active-low
//   gnt_n      out  per-master grant, active-low, registered, at most one low
//   owner      out  index of the granted master, holds its value when idle
//   owner_vld  out  high while a grant is asserted
//   timeout    out  one-cycle pulse when a grant is revoked for timeout
//
// Build option
//   PCI_ARB_ROUND_ROBIN_EN  when defined, the winner is the first requester
//                           found searching upward (with wrap) from the
//                           master after the round-robin pointer. The pointer
//                           follows the owner when it starts a transaction or
//                           times out. When undefined, fixed priority is used
//                           and no pointer exists.
// ---------------------------------------------------------------------------
module pci_arbiter_n #(
    parameter int NUM_MASTERS = 5,
    parameter int TIMEOUT     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req_n,
    input  logic                           frame_n,
    input  logic                           irdy_n,
    output logic [NUM_MASTERS-1:0]         gnt_n,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           owner_vld,
    output logic                           timeout
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = 8;

    // The revoke happens on the edge at which the idle count would reach
    // TIMEOUT, so the grant is visible for exactly TIMEOUT idle cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GNT    = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_SWITCH = 2'd3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]             state_q,     state_d;
    logic [NUM_MASTERS-1:0] gnt_n_q,     gnt_n_d;
    logic [OW-1:0]          owner_q,     owner_d;
    logic                   owner_vld_q, owner_vld_d;
    logic                   timeout_q,   timeout_d;
    logic [CW-1:0]          cnt_q,       cnt_d;
`ifdef PCI_ARB_ROUND_ROBIN_EN
    logic [OW-1:0]          ptr_q,       ptr_d;
`endif

    // -----------------------------------------------------------------------
    // Bus and request decode
    // -----------------------------------------------------------------------
    logic bus_idle;
    logic owner_req_low;   // current grantee still requesting
    logic other_req_low;   // someone other than the grantee is requesting

    assign bus_idle = frame_n & irdy_n;

    // While a grant is active, ~gnt_n_q is the one-hot owner mask, so the
    // owner and non-owner requests fall out of plain masking.
    assign owner_req_low = |(~req_n & ~gnt_n_q);
    assign other_req_low = |(~req_n &  gnt_n_q);

    // -----------------------------------------------------------------------
    // Winner selection, from req_n as sampled on the granting edge
    // -----------------------------------------------------------------------
    logic [OW-1:0] win_idx;
    logic          win_vld;

`ifdef PCI_ARB_ROUND_ROBIN_EN
    int rr_idx;

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        rr_idx  = 0;
        // Search starts one past the pointer and wraps, so the master that
        // last held the bus is considered last.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_MASTERS;
            if (!win_vld && !req_n[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = OW'(rr_idx);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        // Ascending scan where later hits overwrite earlier ones: the
        // highest-index requester wins.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!req_n[i]) begin
                win_vld = 1'b1;
                win_idx = OW'(i);
            end
        end
    end
`endif

    // Active-low one-hot grant vector for the selected winner.
    logic [NUM_MASTERS-1:0] win_gnt_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_win_dec
            assign win_gnt_n[gi] = (win_idx != OW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_n_d     = gnt_n_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
`ifdef PCI_ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif

        case (state_q)
            // IDLE and SWITCH behave alike on exit: grant a pending
            // requester, otherwise rest in IDLE with all grants released.
            // SWITCH is only ever entered for a single cycle.
            ST_IDLE, ST_SWITCH: begin
                gnt_n_d     = '1;
                owner_vld_d = 1'b0;
                state_d     = ST_IDLE;
                if (win_vld) begin
                    state_d     = ST_GNT;
                    gnt_n_d     = win_gnt_n;
                    owner_d     = win_idx;
                    owner_vld_d = 1'b1;
                    cnt_d       = '0;
                end
            end

            ST_GNT: begin
                if (!frame_n) begin
                    // FRAME# seen while granted: treat as our transaction.
                    state_d = ST_BUSY;
`ifdef PCI_ARB_ROUND_ROBIN_EN
                    ptr_d   = owner_q;
`endif
                end else if (!owner_req_low) begin
                    state_d     = ST_SWITCH;
                    gnt_n_d     = '1;
                    owner_vld_d = 1'b0;
                    cnt_d       = '0;
                end else if (bus_idle) begin
                    // Counter only advances on idle-bus cycles, so a master
                    // granted during another master's last data phase is not
                    // penalised for the bus being occupied.
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_SWITCH;
                        gnt_n_d     = '1;
                        owner_vld_d = 1'b0;
                        timeout_d   = 1'b1;
                        cnt_d       = '0;
`ifdef PCI_ARB_ROUND_ROBIN_EN
                        ptr_d       = owner_q;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_BUSY: begin
                // Hidden arbitration: release as soon as another master asks,
                // the running transaction completes without a grant.
                if (other_req_low || (!owner_req_low && bus_idle)) begin
                    state_d     = ST_SWITCH;
                    gnt_n_d     = '1;
                    owner_vld_d = 1'b0;
                    cnt_d       = '0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                gnt_n_d     = '1;
                owner_vld_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers. Reset is asynchronous so grants drop the moment rst rises,
    // even in the middle of a transaction.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_n_q     <= '1;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_n_q     <= gnt_n_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef PCI_ARB_ROUND_ROBIN_EN
    // Pointer starts at the top master so the first search begins at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= OW'(NUM_MASTERS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign gnt_n     = gnt_n_q;
    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign timeout   = timeout_q;

endmodule
